mod_count_checker: RTL and testbench

Passive checker on the far side of the mod-N enable counter interface. Samples the counter's `cnt` bus and the `enable` that drives it every clock, predicts the next legal value, and flags any deviation. Also counts completed wrap-arounds. Sits beside the counter in the lab top level and drives the error LED and a wrap display.

---
 rtl/mod_count_pkg.sv | 15 +
 rtl/mod_count_checker_if.sv | 35 +++
 rtl/mod_next_val.sv | 23 ++
 rtl/mod_count_checker.sv | 149 ++++++++++++++
 tb/tb_mod_count_checker.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mod_count_pkg.sv
// Shared definitions for the mod-N enable counter and its passive checker.
// Holds the default modulus/width and the checker state encoding.
package mod_count_pkg;

    localparam int MODULUS_DEFAULT = 18;
    localparam int CNT_W           = 5;
    localparam int WRAP_W_DEFAULT  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/mod_count_checker_if.sv
// Signal bundle between the counter side (master) and the checker (slave).
// There is no handshake: the checker samples enable/cnt_in/clr on every rising edge.
interface mod_count_checker_if
    import mod_count_pkg::*;
#(
    parameter int WIDTH  = CNT_W,
    parameter int WRAP_W = WRAP_W_DEFAULT
) ();

    logic              enable;
    logic [WIDTH-1:0]  cnt_in;
    logic              clr;

    logic              in_sync;
    logic              err_pulse;
    logic              err_sticky;
    logic [WRAP_W-1:0] err_count;
    logic [WIDTH-1:0]  exp_val;
    logic [WIDTH-1:0]  bad_val;
    logic [WRAP_W-1:0] wrap_count;
    state_t            state;

    modport master (
        output enable, cnt_in, clr,
        input  in_sync, err_pulse, err_sticky, err_count,
        input  exp_val, bad_val, wrap_count, state
    );

    modport slave (
        input  enable, cnt_in, clr,
        output in_sync, err_pulse, err_sticky, err_count,
        output exp_val, bad_val, wrap_count, state
    );

endinterface

// File: rtl/mod_next_val.sv
// Combinational next value of a mod-MODULUS enable counter.
// Arithmetic stays at WIDTH bits, so an out-of-range input simply increments with wrap at 2^WIDTH.
module mod_next_val
    import mod_count_pkg::*;
#(
    parameter int MODULUS = MODULUS_DEFAULT,
    parameter int WIDTH   = CNT_W
) (
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] next_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    always_comb begin
        next_o = cnt_i;
        if (en_i) begin
            next_o = (cnt_i == LAST) ? '0 : cnt_i + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mod_count_checker.sv
// Passive checker for a mod-N enable counter: predicts each sample from the previous
// sample and enable, latches error details, and counts errors and completed wraps.
module mod_count_checker
    import mod_count_pkg::*;
#(
    parameter int MODULUS = MODULUS_DEFAULT,
    parameter int WIDTH   = CNT_W,
    parameter int WRAP_W  = WRAP_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    mod_count_checker_if.slave bus
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  prev_cnt_q, prev_cnt_d;
    logic              prev_en_q, prev_en_d;
    logic              in_sync_q, in_sync_d;
    logic              err_pulse_q, err_pulse_d;
    logic              err_sticky_q, err_sticky_d;
    logic [WRAP_W-1:0] err_count_q, err_count_d;
    logic [WIDTH-1:0]  exp_val_q, exp_val_d;
    logic [WIDTH-1:0]  bad_val_q, bad_val_d;
    logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;

    logic [WIDTH-1:0]  pred;
    logic              legal;
    logic              raise;
    logic              wrap;
    logic [WIDTH-1:0]  exp_src;

    mod_next_val #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_next (
        .cnt_i  (prev_cnt_q),
        .en_i   (prev_en_q),
        .next_o (pred)
    );

    assign legal = ({1'b0, bus.cnt_in} < MOD_EXT);

    // State machine: IDLE and FAULT always recapture; TRACK only advances on a good sample.
    always_comb begin
        state_d    = state_q;
        prev_cnt_d = prev_cnt_q;
        prev_en_d  = prev_en_q;
        raise      = 1'b0;
        wrap       = 1'b0;
        exp_src    = pred;

        case (state_q)
            ST_IDLE: begin
                prev_cnt_d = bus.cnt_in;
                prev_en_d  = bus.enable;
                exp_src    = '0;
                if (legal) begin
                    state_d = ST_TRACK;
                end else begin
                    raise   = 1'b1;
                    state_d = ST_FAULT;
                end
            end
            ST_TRACK: begin
                if (legal && (bus.cnt_in == pred)) begin
                    prev_cnt_d = bus.cnt_in;
                    prev_en_d  = bus.enable;
                    wrap       = prev_en_q && (prev_cnt_q == LAST);
                end else begin
                    raise   = 1'b1;
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                prev_cnt_d = bus.cnt_in;
                prev_en_d  = bus.enable;
                if (legal) begin
                    state_d = ST_TRACK;
                end else begin
                    raise = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Error and wrap bookkeeping; an error in the same cycle as clr still counts as one.
    always_comb begin
        in_sync_d    = (state_d == ST_TRACK);
        err_pulse_d  = raise;
        err_sticky_d = raise | (err_sticky_q & ~bus.clr);
        exp_val_d    = exp_val_q;
        bad_val_d    = bad_val_q;

        err_count_d = bus.clr ? '0 : err_count_q;
        if (raise) begin
            if (bus.clr) begin
                err_count_d = WRAP_W'(1);
            end else if (err_count_q != '1) begin
                err_count_d = err_count_q + WRAP_W'(1);
            end
            exp_val_d = exp_src;
            bad_val_d = bus.cnt_in;
        end

        wrap_count_d = (bus.clr ? '0 : wrap_count_q) + {{(WRAP_W - 1){1'b0}}, wrap};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prev_cnt_q   <= '0;
            prev_en_q    <= 1'b0;
            in_sync_q    <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            exp_val_q    <= '0;
            bad_val_q    <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_cnt_q   <= prev_cnt_d;
            prev_en_q    <= prev_en_d;
            in_sync_q    <= in_sync_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            exp_val_q    <= exp_val_d;
            bad_val_q    <= bad_val_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign bus.in_sync    = in_sync_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_count  = err_count_q;
    assign bus.exp_val    = exp_val_q;
    assign bus.bad_val    = bad_val_q;
    assign bus.wrap_count = wrap_count_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mod_count_checker.sv
// Bench for mod_count_checker: a behavioural model predicts every registered output,
// expectations queue up per edge and a negedge monitor pops and compares them.
module tb_mod_count_checker;
    import mod_count_pkg::*;

    localparam int M  = 18;
    localparam int WD = 5;
    localparam int WW = 8;
    localparam int W  = 1 + 1 + 1 + WW + WD + WD + WW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mod_count_checker_if #(.WIDTH(WD), .WRAP_W(WW)) bus ();

    mod_count_checker #(
        .MODULUS (M),
        .WIDTH   (WD),
        .WRAP_W  (WW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // Reference model state, written in terms of "have a reference yet" / "recovering".
    bit          m_fresh = 1'b1;
    bit          m_recov = 1'b0;
    int          m_prev  = 0;
    int          m_pen   = 0;
    logic        m_sync, m_pulse, m_sticky;
    logic [WW-1:0] m_ecnt, m_wcnt;
    logic [WD-1:0] m_exp, m_bad;

    int ctr = 0;

    task automatic model_edge(input bit r, input bit e, input int c, input bit cl);
        int pred;
        bit legal, err, wrap;
        if (r) begin
            m_fresh = 1'b1; m_recov = 1'b0; m_prev = 0; m_pen = 0;
            m_sync = 1'b0; m_pulse = 1'b0; m_sticky = 1'b0;
            m_ecnt = '0; m_wcnt = '0; m_exp = '0; m_bad = '0;
            return;
        end
        legal = (c < M);
        if (m_prev < M) pred = (m_prev + m_pen) % M;
        else            pred = (m_prev + m_pen) % 32;
        err  = 1'b0;
        wrap = 1'b0;
        if (m_fresh || m_recov) begin
            err = !legal;
        end else begin
            err  = !legal || (c != pred);
            wrap = !err && (m_pen == 1) && (m_prev == M - 1);
        end
        m_sync   = !err;
        m_pulse  = err;
        m_sticky = err || (m_sticky && !cl);
        if (err) begin
            if (cl)                 m_ecnt = 8'd1;
            else if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
            m_exp = m_fresh ? 5'd0 : 5'(pred);
            m_bad = 5'(c);
        end else if (cl) begin
            m_ecnt = 8'd0;
        end
        m_wcnt = (cl ? 8'd0 : m_wcnt) + (wrap ? 8'd1 : 8'd0);
        if (m_fresh || m_recov || !err) begin
            m_prev = c;
            m_pen  = e;
        end
        m_fresh = 1'b0;
        m_recov = err;
    endtask

    task automatic cyc(input bit r, input bit e, input int c, input bit cl);
        rst        = r;
        bus.enable = e;
        bus.cnt_in = 5'(c);
        bus.clr    = cl;
        model_edge(r, e, c, cl);
        @(posedge clk);
        exp_q.push_back({m_sync, m_pulse, m_sticky, m_ecnt, m_exp, m_bad, m_wcnt});
        #1;
    endtask

    // One edge of a well-behaved counter: present ctr, then advance it if enabled.
    task automatic ctr_step(input bit e, input bit cl);
        cyc(1'b0, e, ctr, cl);
        if (e) ctr = (ctr + 1) % M;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e_v, a_v;
        if (exp_q.size() > 0) begin
            e_v = exp_q.pop_front();
            a_v = {bus.in_sync, bus.err_pulse, bus.err_sticky, bus.err_count,
                   bus.exp_val, bus.bad_val, bus.wrap_count};
            n_checks++;
            if (a_v !== e_v) begin
                n_fail++;
                $display("FAIL scoreboard @%0t: got %h, expected %h (sync,pulse,sticky,ecnt,exp,bad,wcnt)",
                         $time, a_v, e_v);
            end
        end
    end

    initial begin
        bus.enable = 1'b0;
        bus.cnt_in = '0;
        bus.clr    = 1'b0;

        repeat (5) cyc(1'b1, 1'b0, 0, 1'b0);
        check("reset_in_sync", bus.in_sync, 0);
        check("reset_err_count", bus.err_count, 0);
        check("reset_state", bus.state, ST_IDLE);

        // Correct counter, enable 20 high / 20 low for 20 periods.
        ctr = 0;
        ctr_step(1'b1, 1'b0);
        check("first_sample_in_sync", bus.in_sync, 1);
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 40; i++) begin
                ctr_step((i < 20), 1'b0);
            end
        end
        check("clean_run_sticky", bus.err_sticky, 0);
        check("clean_run_in_sync", bus.in_sync, 1);

        // Skip 8: counter shows 7 then 9 with enable high.
        while (ctr != 7) ctr_step(1'b1, 1'b0);
        ctr_step(1'b1, 1'b0);
        cyc(1'b0, 1'b1, 9, 1'b0);
        check("skip_err_pulse", bus.err_pulse, 1);
        check("skip_exp_val", bus.exp_val, 8);
        check("skip_bad_val", bus.bad_val, 9);
        check("skip_err_count", bus.err_count, 1);
        check("skip_in_sync_low", bus.in_sync, 0);
        ctr = 10;
        ctr_step(1'b1, 1'b0);
        check("skip_resync", bus.in_sync, 1);
        check("skip_pulse_one_cycle", bus.err_pulse, 0);

        // Illegal value 20 for three cycles.
        ctr_step(1'b1, 1'b1);
        repeat (3) begin
            cyc(1'b0, 1'b1, 20, 1'b0);
            check("illegal_pulse", bus.err_pulse, 1);
            check("illegal_in_sync", bus.in_sync, 0);
        end
        check("illegal_err_count", bus.err_count, 3);
        ctr = 3;
        ctr_step(1'b1, 1'b0);
        check("illegal_recover", bus.in_sync, 1);

        // 4 -> 5 with prev enable low is an error; with enable high it is fine.
        ctr_step(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 5, 1'b0);
        check("hold_err_pulse", bus.err_pulse, 1);
        check("hold_exp_val", bus.exp_val, 4);
        cyc(1'b0, 1'b1, 5, 1'b0);
        ctr = 6;
        while (ctr != 4) ctr_step(1'b1, 1'b0);
        ctr_step(1'b1, 1'b0);
        ctr_step(1'b1, 1'b0);
        check("step_no_err", bus.err_pulse, 0);
        check("step_in_sync", bus.in_sync, 1);

        // 300 wraps after a clear.
        while (ctr == 0) ctr_step(1'b1, 1'b0);
        ctr_step(1'b1, 1'b1);
        repeat (300 * M) ctr_step(1'b1, 1'b0);
        check("wrap_300", bus.wrap_count, 44);

        // 300 errors saturate the error counter.
        ctr_step(1'b1, 1'b1);
        repeat (300) cyc(1'b0, 1'b1, 31, 1'b0);
        check("err_saturate", bus.err_count, 255);
        cyc(1'b0, 1'b1, 31, 1'b1);
        check("clr_err_sticky", bus.err_sticky, 1);
        check("clr_err_count", bus.err_count, 1);
        ctr = 2;
        repeat (5) ctr_step(1'b1, 1'b0);

        // Reset in the middle of tracking.
        check("pre_rst_track", bus.state, ST_TRACK);
        cyc(1'b1, 1'b0, 0, 1'b0);
        check("rst_state", bus.state, ST_IDLE);
        check("rst_wrap_count", bus.wrap_count, 0);
        check("rst_err_sticky", bus.err_sticky, 0);
        ctr = 11;
        repeat (30) ctr_step(1'b1, 1'b0);

        // Random mix of good counting, glitches, clears and resets.
        for (int n = 0; n < 3000; n++) begin
            int r;
            bit e, cl;
            r  = $urandom_range(0, 99);
            e  = 1'($urandom_range(0, 1));
            cl = ($urandom_range(0, 49) == 0);
            if (r < 2) begin
                cyc(1'b1, e, $urandom_range(0, 31), 1'b0);
                ctr = $urandom_range(0, M - 1);
            end else if (r < 10) begin
                cyc(1'b0, e, $urandom_range(0, 31), cl);
                ctr = $urandom_range(0, M - 1);
            end else begin
                ctr_step(e, cl);
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
